// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search controller.
// State encoding and comparator flag patterns.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    WAIT
  } state_t;

  // Legal one-hot flag patterns, packed as {lt, gt, eq}
  localparam logic [2:0] F_LT = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_EQ = 3'b001;

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving a magnitude
// comparator; recovers an N-bit target in at most N probes.
module sar_search_ctrl
  import sar_search_pkg::*;
#(
  parameter int N       = 8,
  parameter int CMP_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] guess,
  input  logic         lt,
  input  logic         gt,
  input  logic         eq,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         early,
  output logic         err
);

  localparam int KW = $clog2(N);
  localparam state_t STEP = (CMP_LAT == 0) ? PROBE : WAIT;

  state_t         state, state_d;
  logic [KW-1:0]  k, k_d;
  logic [N-1:0]   guess_d, result_d;
  logic [N-1:0]   bitk, kept;
  logic           busy_d, done_d, err_d, early_d;
  logic           wait_done;
  logic [2:0]     flags;

  assign flags = {lt, gt, eq};
  assign bitk  = N'(1) << k;
  // acc is implicit: the current guess minus the trial bit when too big
  assign kept  = gt ? (guess & ~bitk) : guess;

  if (CMP_LAT > 0) begin : g_wait
    localparam int CW = $clog2(CMP_LAT + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (state == WAIT && !wait_done) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end

    assign wait_done = (cnt == CW'(CMP_LAT - 1));
  end else begin : g_nowait
    assign wait_done = 1'b1;
  end

  always_comb begin
    state_d  = state;
    k_d      = k;
    guess_d  = guess;
    result_d = result;
    early_d  = early;
    busy_d   = busy;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state)
      IDLE: begin
        guess_d = '0;
        busy_d  = 1'b0;
        if (start) begin
          k_d     = KW'(N - 1);
          guess_d = N'(1) << (N - 1);
          busy_d  = 1'b1;
          state_d = STEP;
        end
      end
      WAIT: begin
        if (wait_done) state_d = PROBE;
      end
      PROBE: begin
        state_d = IDLE;
        guess_d = '0;
        busy_d  = 1'b0;
        case (flags)
          F_EQ: begin
            result_d = guess;
            early_d  = 1'b1;
            done_d   = 1'b1;
          end
          F_LT, F_GT: begin
            if (k == '0) begin
              result_d = kept;
              early_d  = 1'b0;
              done_d   = 1'b1;
            end else begin
              k_d     = k - 1'b1;
              guess_d = kept | (bitk >> 1);
              busy_d  = 1'b1;
              state_d = STEP;
            end
          end
          default: begin
            result_d = '0;
            early_d  = 1'b0;
            err_d    = 1'b1;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        guess_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      guess  <= '0;
      result <= '0;
      early  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      k      <= k_d;
      guess  <= guess_d;
      result <= result_d;
      early  <= early_d;
      busy   <= busy_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: two instances (CMP_LAT 0 and 2) against
// a combinational comparator model and a binary-search reference.
module tb_sar_search_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;

  logic       start0 = 1'b0, start2 = 1'b0;
  logic [7:0] tgt0 = '0, tgt2 = '0;
  logic       corrupt0 = 1'b0;
  logic [7:0] guess0, guess2, result0, result2;
  logic       lt0, gt0, eq0, lt2, gt2, eq2;
  logic       busy0, done0, early0, err0;
  logic       busy2, done2, early2, err2;

  logic       sel = 1'b0;
  logic [7:0] guess_m, result_m;
  logic       busy_m, done_m, early_m, err_m;

  always #5 clk = ~clk;

  assign lt0 = corrupt0 ? 1'b1 : (guess0 < tgt0);
  assign gt0 = corrupt0 ? 1'b1 : (guess0 > tgt0);
  assign eq0 = corrupt0 ? 1'b0 : (guess0 == tgt0);
  assign lt2 = guess2 < tgt2;
  assign gt2 = guess2 > tgt2;
  assign eq2 = guess2 == tgt2;

  assign guess_m  = sel ? guess2  : guess0;
  assign result_m = sel ? result2 : result0;
  assign busy_m   = sel ? busy2   : busy0;
  assign done_m   = sel ? done2   : done0;
  assign early_m  = sel ? early2  : early0;
  assign err_m    = sel ? err2    : err0;

  sar_search_ctrl #(.N(8), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .guess(guess0),
    .lt(lt0), .gt(gt0), .eq(eq0), .busy(busy0), .done(done0),
    .result(result0), .early(early0), .err(err0)
  );

  sar_search_ctrl #(.N(8), .CMP_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .guess(guess2),
    .lt(lt2), .gt(gt2), .eq(eq2), .busy(busy2), .done(done2),
    .result(result2), .early(early2), .err(err2)
  );

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({guess0, busy0, done0, err0, result0, early0} !== 20'h0) begin
      bad++;
      $display("FAIL reset_lat0: got %h want 0",
               {guess0, busy0, done0, err0, result0, early0});
    end
    total++;
    if ({guess2, busy2, done2, err2, result2, early2} !== 20'h0) begin
      bad++;
      $display("FAIL reset_lat2: got %h want 0",
               {guess2, busy2, done2, err2, result2, early2});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Reference: plain binary search over bit weights, high to low
  task automatic test_search(input bit s, input logic [7:0] t,
                             input bit mid, input string nm);
    logic [7:0] exp_g[$];
    logic [7:0] acc, g;
    bit         erl;
    int         per, np;
    per = s ? 3 : 1;
    acc = '0;
    erl = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      g = acc + 8'(1 << b);
      exp_g.push_back(g);
      if (g == t) begin
        erl = 1'b1;
        break;
      end
      if (g < t) acc = g;
    end
    np = exp_g.size();
    sel = s;
    if (s) tgt2 = t; else tgt0 = t;
    @(negedge clk);
    if (s) start2 = 1'b1; else start0 = 1'b1;
    for (int e = 0; e <= np * per + 1; e++) begin
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
      if (e < np * per) begin
        total++;
        if (guess_m !== exp_g[e / per] || busy_m !== 1'b1
            || done_m !== 1'b0) begin
          bad++;
          $display("FAIL %s probe e=%0d: guess/busy/done %h/%b/%b want %h/1/0",
                   nm, e, guess_m, busy_m, done_m, exp_g[e / per]);
        end
      end else if (e == np * per) begin
        total++;
        if (done_m !== 1'b1 || busy_m !== 1'b0 || result_m !== t
            || early_m !== erl || guess_m !== 8'h00) begin
          bad++;
          $display("FAIL %s done e=%0d: done/busy/res/early/guess %b/%b/%h/%b/%h want 1/0/%h/%b/00",
                   nm, e, done_m, busy_m, result_m, early_m, guess_m,
                   t, erl);
        end
      end else begin
        total++;
        if (done_m !== 1'b0 || busy_m !== 1'b0 || result_m !== t
            || early_m !== erl) begin
          bad++;
          $display("FAIL %s hold: done/busy/res/early %b/%b/%h/%b want 0/0/%h/%b",
                   nm, done_m, busy_m, result_m, early_m, t, erl);
        end
      end
      if (mid && e == 1 && e + 1 < np * per) begin
        if (s) start2 = 1'b1; else start0 = 1'b1;
      end
    end
  endtask

  task automatic test_err();
    sel = 1'b0;
    tgt0 = 8'h5A;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    corrupt0 = 1'b1;
    @(negedge clk);
    corrupt0 = 1'b0;
    total++;
    if (err0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0
        || result0 !== 8'h00 || early0 !== 1'b0 || guess0 !== 8'h00) begin
      bad++;
      $display("FAIL err_pulse: err/done/busy/res/early/guess %b/%b/%b/%h/%b/%h want 1/0/0/00/0/00",
               err0, done0, busy0, result0, early0, guess0);
    end
    @(negedge clk);
    total++;
    if (err0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err/busy/done %b/%b/%b want 0/0/0",
               err0, busy0, done0);
    end
    test_search(1'b0, 8'h33, 1'b0, "after_err");
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    tgt0 = 8'hFF;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({guess0, busy0, done0, err0, result0, early0} !== 20'h0) begin
      bad++;
      $display("FAIL reset_mid: got %h want 0",
               {guess0, busy0, done0, err0, result0, early0});
    end
    @(negedge clk);
    rst = 1'b0;
    test_search(1'b0, 8'hFF, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      test_search(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_search(1'b0, 8'h00, 1'b0, "lat0_t00");
    test_search(1'b0, 8'h80, 1'b0, "lat0_t80");
    test_search(1'b0, 8'h5A, 1'b0, "lat0_t5a");
    test_search(1'b1, 8'h5A, 1'b1, "lat2_t5a");
    test_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
